// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a shared UART transmitter.
// A grant is held for a whole packet, with an idle gap after every byte.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BIT_MAX    = 8,
    parameter int GAP_CYCLES = 5208,
    parameter int HOLD_MAX   = 520800
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BIT_MAX-1:0] req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         grant,
    output logic [BIT_MAX-1:0]         tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic                       arb_busy,
    output logic                       hold_timeout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [GW-1:0] GAP_END  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [HW-1:0] HOLD_END = HW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam logic [IW-1:0] PTR_INIT = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE,
        GAP,
        HOLD
    } state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [IW-1:0]      owner, owner_n;
    logic [IW-1:0]      last, last_n;
    logic               last_flag, last_flag_n;
    logic [GW-1:0]      gap_cnt, gap_n;
    logic [HW-1:0]      hold_cnt, hold_n;
    logic [BIT_MAX-1:0] data_n;
    logic               timeout_n;
    logic               byte_done;
    logic [IW-1:0]      pick;

    logic [BIT_MAX-1:0] lane [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane[i] = req_data[i*BIT_MAX +: BIT_MAX];
    end

    // First valid index after the previous owner, wrapping around.
    function automatic logic [IW-1:0] rr_pick(
        input logic [NUM_REQ-1:0] v,
        input logic [IW-1:0]      p
    );
        logic [IW-1:0] r;
        logic          found;
        int            j;
        r     = p;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(p) + k) % NUM_REQ;
            if (!found && v[j]) begin
                found = 1'b1;
                r     = IW'(j);
            end
        end
        return r;
    endfunction

    assign pick      = rr_pick(req_valid, last);
    assign tx_start  = (state == LOAD);
    assign req_ready = grant & {NUM_REQ{state == LOAD}};
    assign arb_busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            grant        <= '0;
            owner        <= '0;
            last         <= PTR_INIT;
            last_flag    <= 1'b0;
            gap_cnt      <= '0;
            hold_cnt     <= '0;
            tx_data      <= '0;
            hold_timeout <= 1'b0;
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            owner        <= owner_n;
            last         <= last_n;
            last_flag    <= last_flag_n;
            gap_cnt      <= gap_n;
            hold_cnt     <= hold_n;
            tx_data      <= data_n;
            hold_timeout <= timeout_n;
        end
    end

    always_comb begin
        state_n     = state;
        grant_n     = grant;
        owner_n     = owner;
        last_n      = last;
        last_flag_n = last_flag;
        gap_n       = gap_cnt;
        hold_n      = hold_cnt;
        data_n      = tx_data;
        timeout_n   = 1'b0;
        byte_done   = 1'b0;

        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    owner_n      = pick;
                    grant_n      = '0;
                    grant_n[pick] = 1'b1;
                    data_n       = lane[pick];
                    state_n      = LOAD;
                end
            end
            LOAD: begin
                last_flag_n = req_last[owner];
                state_n     = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        byte_done = 1'b1;
                    end else begin
                        gap_n   = '0;
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_END) begin
                    byte_done = 1'b1;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            HOLD: begin
                // A byte arriving on the timeout cycle still goes out.
                if (req_valid[owner]) begin
                    data_n  = lane[owner];
                    state_n = LOAD;
                end else if (hold_cnt == HOLD_END) begin
                    timeout_n = 1'b1;
                    last_n    = owner;
                    grant_n   = '0;
                    state_n   = IDLE;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase

        if (byte_done) begin
            if (last_flag) begin
                last_n  = owner;
                grant_n = '0;
                state_n = IDLE;
            end else if (req_valid[owner]) begin
                data_n  = lane[owner];
                state_n = LOAD;
            end else begin
                hold_n  = '0;
                state_n = HOLD;
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ requesters; serialises whole packets so that bytes from different sources never interleave on the line.
- Sits between the application sources and the transmitter. It drives the transmitter's start/data inputs and watches its busy flag.
- Uses round-robin arbitration, holds the grant until the requester's last byte, and inserts a configurable idle gap between bytes.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BIT_MAX, 8, data bits per byte
GAP_CYCLES, 5208, idle clk cycles after each byte (0 = no gap)
HOLD_MAX, 520800, max clk cycles a locked requester may stall mid-packet before the grant is released

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  NUM_REQ*BIT_MAX  per-requester byte; requester i uses bits [i*BIT_MAX +: BIT_MAX]
req_last  in  NUM_REQ  byte presented is the last byte of the packet
req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
grant  out  NUM_REQ  one-hot current owner; all zero when none
tx_data  out  BIT_MAX  byte to the transmitter, registered
tx_start  out  1  one-cycle start pulse to the transmitter
tx_busy  in  1  transmitter busy level
arb_busy  out  1  high in every state except IDLE
hold_timeout  out  1  one-cycle pulse when a lock is released by HOLD_MAX

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; grant=0, req_ready=0, tx_start=0, tx_data=0, arb_busy=0, hold_timeout=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins the first contest.
  - Gap and hold counters are cleared.
- Reset mid-transfer:
  - Outputs drop immediately.
  - The byte in flight at the transmitter is not tracked; its remaining bits are not the arbiter's concern.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP, HOLD.
- IDLE:
  - If any req_valid bit is set, pick the first set index searching last+1, last+2, ... modulo NUM_REQ.
  - Register that index in grant and go to LOAD next cycle.
  - Otherwise stay.
- LOAD (exactly 1 cycle):
  - tx_data <= the granted requester's data.
  - tx_start=1 and req_ready[g]=1 in the same cycle.
  - Latch req_last[g] into last_flag, then go to WAIT_BUSY.
  - The requester must hold valid/data stable while in IDLE, HOLD or GAP with the grant; a byte is consumed only on req_ready.
- WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE. The transmitter raises busy within 1–2 cycles of tx_start.
- WAIT_DONE: stay while tx_busy=1. When tx_busy=0, go to GAP, or skip GAP if GAP_CYCLES=0 and apply the GAP exit rules directly.
- GAP: count GAP_CYCLES cycles (0..GAP_CYCLES-1), then exit:
  - last_flag=1: last <= g, grant <= 0, go to IDLE. Arbitration is re-evaluated in IDLE on the next cycle.
  - last_flag=0 and req_valid[g]=1: go to LOAD.
  - last_flag=0 and req_valid[g]=0: go to HOLD with the hold counter at 0.
- HOLD:
  - req_valid[g]=1: go to LOAD.
  - Counter reaches HOLD_MAX-1: pulse hold_timeout, last <= g, grant <= 0, go to IDLE.
  - A valid arriving on the same cycle as the timeout wins, i.e. goes to LOAD.
- While grant is locked, other requesters' valid bits are ignored. Their req_ready stays 0.
- Simultaneous requests are resolved strictly by round-robin; a requester never wins twice in a row while another is waiting.
- tx_start pulses exactly once per accepted byte, and never while tx_busy=1 from the previous byte.
- Counter widths hold HOLD_MAX-1 and GAP_CYCLES-1 without overflow.

Test Plan:
- Req0 sends a 3-byte packet 0x41,0x42,0x43 (last on 0x43), with a TX model whose busy lasts 10 cycles and GAP_CYCLES=4 -> three tx_start pulses, each ≥14 cycles apart; tx_data sequence 41,42,43; grant=0001 throughout; grant=0 after the final gap.
- Req1 and req3 assert together from reset, single-byte packets -> req1 served first; then req3; then req1 again if re-asserted; grant sequence 0010, 1000, 0010.
- Req0 is mid-packet (last=0) while req2 asserts -> req2 sees no req_ready until req0 presents last; req2's byte follows req0's final byte.
- Req0 drops valid mid-packet with HOLD_MAX=20 -> hold_timeout pulses 20 cycles after entering HOLD; grant=0; a pending req1 is granted next.
- rst asserted while in WAIT_DONE -> tx_start, grant and arb_busy are 0 immediately; after release, req0 is served first (pointer reset).
- GAP_CYCLES=0, back-to-back bytes -> next tx_start occurs the cycle after tx_busy falls plus the LOAD cycle (≤2 cycles); no byte is dropped.
